// File: rtl/psd_event_fifo.sv
// Store-and-forward event FIFO between the PSD readout block and the DMA AXI-Stream port.
// Words are held until a full packet is stored, except when a packet is longer than the FIFO.
module psd_event_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic          mclk,
  input  logic          mrst_n,
  input  logic [31:0]   s_tdata,
  input  logic          s_tvalid,
  input  logic          s_tlast,
  output logic          s_tready,
  output logic [31:0]   m_tdata,
  output logic          m_tvalid,
  output logic          m_tlast,
  input  logic          m_tready,
  output logic [AW:0]   level,
  output logic [AW:0]   pkt_cnt,
  output logic          overflow,
  input  logic          ovf_clr
);

  logic [32:0] mem [DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0] level_q, level_d;
  logic [AW:0] pkt_cnt_q, pkt_cnt_d;
  logic        overflow_q, overflow_d;
  logic        full, empty, wr_en, rd_en, pkt_inc, pkt_dec;
  logic [32:0] head;

  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);

  assign s_tready = ~full;
  assign wr_en    = s_tvalid & ~full;

  // Cut-through when full with no complete packet, otherwise an oversized packet deadlocks.
  assign m_tvalid = ~empty & ((pkt_cnt_q != '0) | full);
  assign rd_en    = m_tvalid & m_tready;

  assign head    = mem[rd_ptr_q[AW-1:0]];
  assign m_tdata = head[31:0];
  assign m_tlast = head[32];

  assign pkt_inc = wr_en & s_tlast;
  assign pkt_dec = rd_en & m_tlast;

  assign level    = level_q;
  assign pkt_cnt  = pkt_cnt_q;
  assign overflow = overflow_q;

  always_comb begin
    level_d = level_q;
    unique case ({wr_en, rd_en})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    unique case ({pkt_inc, pkt_dec})
      2'b10:   pkt_cnt_d = pkt_cnt_q + 1'b1;
      2'b01:   pkt_cnt_d = pkt_cnt_q - 1'b1;
      default: pkt_cnt_d = pkt_cnt_q;
    endcase
  end

  // A dropped write wins over a coincident clear.
  always_comb begin
    overflow_d = overflow_q;
    if (s_tvalid && full) begin
      overflow_d = 1'b1;
    end else if (ovf_clr) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge mclk or negedge mrst_n) begin
    if (!mrst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      pkt_cnt_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q    <= level_d;
      pkt_cnt_q  <= pkt_cnt_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge mclk) begin
    if (wr_en) mem[wr_ptr_q[AW-1:0]] <= {s_tlast, s_tdata};
  end

endmodule
